// File: rtl/rtc_time_core.sv
// Time-of-day core: 1 s prescaler, BCD hh:mm:ss, 12/24-hour display, day-carry and second-tick pulses.
// Defining RTC_TIME_CORE_ALARM_EN adds a registered hour/minute alarm comparator.
module rtc_time_core #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       En,
  input  logic       Mode12,
  input  logic       AdjMinKey,
  input  logic       AdjHrKey,
`ifdef RTC_TIME_CORE_ALARM_EN
  input  logic       AlarmOn,
  input  logic [7:0] AlarmHour,
  input  logic [7:0] AlarmMin,
  output logic       Alarm,
`endif
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [7:0] Second,
  output logic       PM,
  output logic       SecTick,
  output logic       DayCarry
);

  localparam int unsigned BCD_W  = 8;
  localparam int unsigned HBIN_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0]  cnt;
  logic              tick_c;
  logic [BCD_W-1:0]  hour24;
  logic              sec_end_c;
  logic              min_sec_end_c;
  logic              day_end_c;
  logic [HBIN_W-1:0] h_bin_c;
  logic [HBIN_W-1:0] h12_bin_c;
  logic [BCD_W-1:0]  h12_bcd_c;

  // BCD pair increment that wraps to 00 after max_v.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v,
                                               input logic [BCD_W-1:0] max_v);
    if (v == max_v)
      return '0;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick_c        = En && (cnt == CNT_MAX);
  assign sec_end_c     = (Second == 8'h59);
  assign min_sec_end_c = sec_end_c && (Minute == 8'h59);
  assign day_end_c     = min_sec_end_c && (hour24 == 8'h23);

  // Prescaler: one enable per TICKS_PER_SEC enabled cycles.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR)
      cnt <= '0;
    else if (En)
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
  end

  // Time fields; keys only matter on a tick, and adjust wraps never carry.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      Second   <= '0;
      Minute   <= '0;
      hour24   <= '0;
      SecTick  <= 1'b0;
      DayCarry <= 1'b0;
    end else begin
      SecTick  <= tick_c;
      DayCarry <= tick_c && day_end_c && !AdjHrKey;
      if (tick_c) begin
        Second <= bcd_inc(Second, 8'h59);
        if (AdjMinKey || sec_end_c)
          Minute <= bcd_inc(Minute, 8'h59);
        if (AdjHrKey || min_sec_end_c)
          hour24 <= bcd_inc(hour24, 8'h23);
      end
    end
  end

  // 12-hour view: 00 -> 12, 13..23 -> 01..11.
  always_comb begin
    h_bin_c   = HBIN_W'(hour24[7:4]) * HBIN_W'(10) + HBIN_W'(hour24[3:0]);
    h12_bin_c = h_bin_c;
    if (h_bin_c == '0)
      h12_bin_c = HBIN_W'(12);
    else if (h_bin_c > HBIN_W'(12))
      h12_bin_c = h_bin_c - HBIN_W'(12);
    if (h12_bin_c >= HBIN_W'(10))
      h12_bcd_c = {4'd1, 4'(h12_bin_c - HBIN_W'(10))};
    else
      h12_bcd_c = {4'd0, 4'(h12_bin_c)};
  end

  assign Hour = Mode12 ? h12_bcd_c : hour24;
  assign PM   = (hour24 >= 8'h12);

`ifdef RTC_TIME_CORE_ALARM_EN
  // Alarm holds for the whole matching minute and follows AlarmOn within one cycle.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR)
      Alarm <= 1'b0;
    else
      Alarm <= AlarmOn && (hour24 == AlarmHour) && (Minute == AlarmMin);
  end
`endif

endmodule

// File: tb/tb_rtc_time_core.sv
// Bench for rtc_time_core with a 4-cycle second: scoreboard of expected tick results plus display vector table.
module tb_rtc_time_core;

  localparam int unsigned TPS = 4;
  localparam int unsigned CW  = 3;

  logic       CP = 1'b0;
  logic       nCR, En, Mode12, AdjMinKey, AdjHrKey;
  logic [7:0] Hour, Minute, Second;
  logic       PM, SecTick, DayCarry;
`ifdef RTC_TIME_CORE_ALARM_EN
  logic       AlarmOn;
  logic [7:0] AlarmHour, AlarmMin;
  logic       Alarm;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct { int h; int m; int s; bit dc; } exp_t;
  exp_t sb[$];
  int mh, mm, ms;

  typedef struct { int h; int m; int s; bit m12; logic [7:0] hour; bit pm; } disp_vec_t;
  disp_vec_t vt [8];

  rtc_time_core #(.TICKS_PER_SEC(TPS), .CNT_W(CW)) dut (
    .CP(CP), .nCR(nCR), .En(En), .Mode12(Mode12),
    .AdjMinKey(AdjMinKey), .AdjHrKey(AdjHrKey),
`ifdef RTC_TIME_CORE_ALARM_EN
    .AlarmOn(AlarmOn), .AlarmHour(AlarmHour), .AlarmMin(AlarmMin), .Alarm(Alarm),
`endif
    .Hour(Hour), .Minute(Minute), .Second(Second), .PM(PM),
    .SecTick(SecTick), .DayCarry(DayCarry)
  );

  always #5 CP = ~CP;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [7:0] disp_hour(input int h, input logic m12);
    if (!m12) return to_bcd(h);
    if (h == 0) return to_bcd(12);
    if (h > 12) return to_bcd(h - 12);
    return to_bcd(h);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference time step on a tick, applied to the bench's own binary time.
  task automatic expect_tick(input bit adjm, input bit adjh);
    exp_t e;
    bit nat_m, nat_h;
    chk("pending_tick", 8'(sb.size()), 8'd0);
    nat_m = (ms == 59);
    nat_h = (mm == 59) && (ms == 59);
    e.dc  = (mh == 23) && (mm == 59) && (ms == 59) && !adjh;
    ms = (ms + 1) % 60;
    if (adjm || nat_m) mm = (mm + 1) % 60;
    if (adjh || nat_h) mh = (mh + 1) % 24;
    e.h = mh; e.m = mm; e.s = ms;
    sb.push_back(e);
  endtask

  // Every SecTick must match a queued expectation; DayCarry never appears alone.
  always @(posedge CP) begin
    exp_t e;
    #1;
    if (SecTick === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_sectick: got SecTick=1, expected 0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("tick_sec", Second, to_bcd(e.s));
        chk("tick_min", Minute, to_bcd(e.m));
        chk("tick_hour", Hour, disp_hour(e.h, Mode12));
        chk("tick_pm", 8'(PM), 8'(e.h >= 12));
        chk("tick_daycarry", 8'(DayCarry), 8'(e.dc));
      end
    end else begin
      chk("daycarry_idle", 8'(DayCarry), 8'd0);
    end
  end

  task automatic cycles_en(input int n);
    En = 1'b1;
    repeat (n) @(negedge CP);
    En = 1'b0;
  endtask

  task automatic tick(input bit adjm, input bit adjh);
    AdjMinKey = adjm;
    AdjHrKey  = adjh;
    En = 1'b1;
    repeat (3) @(negedge CP);
    expect_tick(adjm, adjh);
    @(negedge CP);
    En = 1'b0;
    AdjMinKey = 1'b0;
    AdjHrKey  = 1'b0;
  endtask

  task automatic idle(input int n);
    En = 1'b0;
    repeat (n) @(negedge CP);
    chk("frozen_sec", Second, to_bcd(ms));
  endtask

  task automatic do_reset();
    nCR = 1'b0;
    En  = 1'b0;
    #1;
    chk("rst_sec", Second, 8'h00);
    chk("rst_min", Minute, 8'h00);
    chk("rst_hour", Hour, Mode12 ? 8'h12 : 8'h00);
    chk("rst_sectick", 8'(SecTick), 8'd0);
    chk("rst_daycarry", 8'(DayCarry), 8'd0);
    chk("rst_pending", 8'(sb.size()), 8'd0);
    sb.delete();
    mh = 0; mm = 0; ms = 0;
    @(negedge CP);
    nCR = 1'b1;
  endtask

  // Reach th:tm:ts using pre-roll seconds then per-field adjust keys.
  task automatic goto_time(input int th, input int tm, input int ts);
    int n, p;
    do_reset();
    n = (th > tm) ? th : tm;
    p = ((ts - n) % 60 + 60) % 60;
    repeat (p) tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick(mm != tm, mh != th);
    chk("goto_hour", Hour, to_bcd(th));
    chk("goto_min", Minute, to_bcd(tm));
    chk("goto_sec", Second, to_bcd(ts));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0,  0, 0,  1'b1, 8'h12, 1'b0};
    vt[1] = '{12, 0, 12, 1'b1, 8'h12, 1'b1};
    vt[2] = '{13, 0, 13, 1'b1, 8'h01, 1'b1};
    vt[3] = '{23, 0, 23, 1'b1, 8'h11, 1'b1};
    vt[4] = '{0,  0, 0,  1'b0, 8'h00, 1'b0};
    vt[5] = '{12, 0, 12, 1'b0, 8'h12, 1'b1};
    vt[6] = '{13, 0, 13, 1'b0, 8'h13, 1'b1};
    vt[7] = '{23, 0, 23, 1'b0, 8'h23, 1'b1};

    nCR = 1'b0; En = 1'b0; Mode12 = 1'b0; AdjMinKey = 1'b0; AdjHrKey = 1'b0;
`ifdef RTC_TIME_CORE_ALARM_EN
    AlarmOn = 1'b0; AlarmHour = 8'h07; AlarmMin = 8'h00;
`endif
    mh = 0; mm = 0; ms = 0;
    #2;
    chk("init_sec", Second, 8'h00);
    chk("init_min", Minute, 8'h00);
    chk("init_hour24", Hour, 8'h00);
    chk("init_pm", 8'(PM), 8'd0);
    chk("init_sectick", 8'(SecTick), 8'd0);
    Mode12 = 1'b1;
    #1;
    chk("init_hour12", Hour, 8'h12);
    Mode12 = 1'b0;
    @(negedge CP);
    nCR = 1'b1;

    // First second after release, then freeze with a partial count held.
    tick(1'b0, 1'b0);
    idle(10);
    cycles_en(2);
    idle(10);
    cycles_en(1);
    expect_tick(1'b0, 1'b0);
    cycles_en(1);

    // Reset mid-second restarts the prescaler.
    cycles_en(2);
    do_reset();
    tick(1'b0, 1'b0);

    // Natural day rollover.
    goto_time(23, 59, 58);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Minute key plus natural carry increments minute once.
    goto_time(10, 59, 59);
    tick(1'b1, 1'b0);
    chk("adjmin_hour", Hour, 8'h11);
    chk("adjmin_min", Minute, 8'h00);

    // Hour adjust wrap gives no DayCarry.
    goto_time(23, 30, 10);
    tick(1'b0, 1'b1);
    chk("adjhr_hour", Hour, 8'h00);
    chk("adjhr_sec", Second, 8'h11);

    // Keys only count on the tick cycle itself.
    AdjMinKey = 1'b1; AdjHrKey = 1'b1; En = 1'b1;
    repeat (3) @(negedge CP);
    AdjMinKey = 1'b0; AdjHrKey = 1'b0;
    expect_tick(1'b0, 1'b0);
    @(negedge CP);
    En = 1'b1;
    repeat (3) @(negedge CP);
    AdjMinKey = 1'b1; AdjHrKey = 1'b1;
    expect_tick(1'b1, 1'b1);
    @(negedge CP);
    En = 1'b0; AdjMinKey = 1'b0; AdjHrKey = 1'b0;
    chk("late_key_time", Hour, 8'h01);

    // Display mode table.
    for (int i = 0; i < 8; i++) begin
      goto_time(vt[i].h, vt[i].m, vt[i].s);
      Mode12 = vt[i].m12;
      #1;
      chk("disp_hour", Hour, vt[i].hour);
      chk("disp_pm", 8'(PM), 8'(vt[i].pm));
      chk("disp_min", Minute, to_bcd(vt[i].m));
      chk("disp_sec", Second, to_bcd(vt[i].s));
      Mode12 = ~Mode12;
      #1;
      chk("toggle_min", Minute, to_bcd(vt[i].m));
      chk("toggle_sec", Second, to_bcd(vt[i].s));
      Mode12 = 1'b0;
      @(negedge CP);
    end

`ifdef RTC_TIME_CORE_ALARM_EN
    goto_time(6, 59, 58);
    AlarmOn = 1'b1;
    tick(1'b0, 1'b0);
    chk("alarm_before", 8'(Alarm), 8'd0);
    tick(1'b0, 1'b0);
    chk("alarm_lag_rise", 8'(Alarm), 8'd0);
    @(posedge CP); #1;
    chk("alarm_rise", 8'(Alarm), 8'd1);
    @(negedge CP);
    AlarmOn = 1'b0;
    @(posedge CP); #1;
    chk("alarm_off", 8'(Alarm), 8'd0);
    AlarmOn = 1'b1;
    @(posedge CP); #1;
    chk("alarm_on_again", 8'(Alarm), 8'd1);
    @(negedge CP);
    repeat (59) tick(1'b0, 1'b0);
    chk("alarm_hold", 8'(Alarm), 8'd1);
    tick(1'b0, 1'b0);
    chk("alarm_lag_fall", 8'(Alarm), 8'd1);
    @(posedge CP); #1;
    chk("alarm_fall", 8'(Alarm), 8'd0);
    @(negedge CP);
    goto_time(7, 0, 7);
    @(posedge CP); #1;
    chk("alarm_match", 8'(Alarm), 8'd1);
    nCR = 1'b0;
    #1;
    chk("alarm_rst", 8'(Alarm), 8'd0);
    chk("alarm_rst_sec", Second, 8'h00);
    chk("alarm_rst_hour", Hour, 8'h00);
    mh = 0; mm = 0; ms = 0;
    @(negedge CP);
    nCR = 1'b1;
    AlarmOn = 1'b0;
`endif

    repeat (3) @(negedge CP);
    chk("pending_end", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
